prod_accum: RTL



---
 rtl/prod_accum_pkg.sv | 14 +
 rtl/prod_accum_add.sv | 34 +++
 rtl/prod_accum.sv | 112 +++++++++++
 3 files changed

// File: rtl/prod_accum_pkg.sv
// Shared types and widths for the prod_accum product accumulator.
// The FSM state type and fixed port widths live here so the top and datapath agree.
package prod_accum_pkg;

    localparam int PROD_W  = 16;
    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : prod_accum_pkg

// File: rtl/prod_accum_add.sv
// Sum-and-overflow datapath: adds one product at ACC_W+1 bits and tracks the frame overflow flag.
// Build option: define PROD_ACCUM_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping.
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = 24
)(
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    input  logic              i_first,
    input  logic              i_ovf,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_full;
    logic             w_ovf;

    // The first product of a frame starts from zero and clears any old overflow.
    assign w_base = i_first ? '0 : i_acc;
    assign w_full = {1'b0, w_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign w_ovf  = w_full[ACC_W] | (i_ovf & ~i_first);

`ifdef PROD_ACCUM_SAT_EN
    // Once the frame has overflowed the sum is pinned at full scale until the frame ends.
    assign o_sum = w_ovf ? '1 : w_full[ACC_W-1:0];
`else
    assign o_sum = w_full[ACC_W-1:0];
`endif

    assign o_ovf = w_ovf;

endmodule : prod_accum_add

// File: rtl/prod_accum.sv
// Product accumulator: sums up to N_TERMS unsigned 16-bit products per frame and holds the result for a handshake.
// Build option: PROD_ACCUM_SAT_EN selects saturating instead of wrapping accumulation.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int N_TERMS = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROD_W-1:0]  in_prod,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_ovf,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [COUNT_W-1:0] LP_N_TERMS = COUNT_W'(N_TERMS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [COUNT_W-1:0] r_count;
    logic               r_ovf;

    logic               w_accept;
    logic               w_first;
    logic               w_close;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [ACC_W-1:0]   w_sum;
    logic               w_sum_ovf;

    // NOTE: every output of this block is assigned a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_first     = 1'b0;
        w_accept    = 1'b0;
        w_count_nxt = r_count + COUNT_W'(1);
        w_close     = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready    = 1'b1;
                w_first     = 1'b1;
                w_accept    = in_valid;
                w_count_nxt = COUNT_W'(1);
            end
            ACCUM: begin
                in_ready = 1'b1;
                w_accept = in_valid;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // in_last and the term limit coinciding still close the frame exactly once.
        w_close = in_last || (w_count_nxt == LP_N_TERMS);
        if (w_accept) begin
            w_state_nxt = w_close ? HOLD : ACCUM;
        end
    end

    prod_accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (in_prod),
        .i_first (w_first),
        .i_ovf   (r_ovf),
        .o_sum   (w_sum),
        .o_ovf   (w_sum_ovf)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            r_ovf   <= w_sum_ovf;
        end
    end

    assign out_acc   = r_acc;
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule : prod_accum
